// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - request/response and main_memory bus bundle for mem_arbiter
interface mem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  // fetch port (read-only)
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;
  // datapath load/store port
  logic              dp_req;
  logic              dp_we;
  logic [ADDR_W-1:0] dp_addr;
  logic [DATA_W-1:0] dp_wdata;
  logic              dp_gnt;
  logic              dp_valid;
  logic [DATA_W-1:0] dp_rdata;
  // main_memory side
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_data_out;

  // arbiter view
  modport slave (
    input  if_req, if_addr, dp_req, dp_we, dp_addr, dp_wdata, mem_data_out,
    output if_gnt, if_valid, if_rdata, dp_gnt, dp_valid, dp_rdata,
           mem_address, mem_data_in, mem_rd, mem_wr
  );

  // requester/memory environment view
  modport master (
    output if_req, if_addr, dp_req, dp_we, dp_addr, dp_wdata, mem_data_out,
    input  if_gnt, if_valid, if_rdata, dp_gnt, dp_valid, dp_rdata,
           mem_address, mem_data_in, mem_rd, mem_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port fetch/datapath arbiter and sequencer for single-ported main_memory
module mem_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int RR_MODE  = 0,
  parameter int MAX_WAIT = 3
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus,
  output logic          busy
);

  localparam int LC_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int WC_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            r_state;
  logic              r_sel_dp;     // winner of the current transaction: 1 = datapath
  logic              r_we;
  logic [LC_W-1:0]   r_lat_cnt;
  logic [WC_W-1:0]   r_wait_cnt;   // consecutive lost arbitrations of fetch
  logic              r_last_if;    // 1 = fetch was granted most recently
  logic              r_busy;
  logic              r_if_gnt;
  logic              r_dp_gnt;
  logic              r_if_valid;
  logic              r_dp_valid;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dp_rdata;
  logic [ADDR_W-1:0] r_mem_address;
  logic [DATA_W-1:0] r_mem_data_in;
  logic              r_mem_rd;
  logic              r_mem_wr;

  logic              w_any_req;
  logic              w_pick_dp;

  // Pick the winner among the requests currently presented
  always_comb begin
    w_any_req = bus.if_req | bus.dp_req;
    w_pick_dp = 1'b0;
    if (bus.dp_req && !bus.if_req) begin
      w_pick_dp = 1'b1;
    end else if (bus.dp_req && bus.if_req) begin
      if (RR_MODE != 0) begin
        w_pick_dp = r_last_if;
      end else begin
        w_pick_dp = (r_wait_cnt < WC_W'(MAX_WAIT));
      end
    end
  end

  // Sequencer: one memory command at a time, all outputs registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_sel_dp      <= 1'b0;
      r_we          <= 1'b0;
      r_lat_cnt     <= '0;
      r_wait_cnt    <= '0;
      r_last_if     <= 1'b0;
      r_busy        <= 1'b0;
      r_if_gnt      <= 1'b0;
      r_dp_gnt      <= 1'b0;
      r_if_valid    <= 1'b0;
      r_dp_valid    <= 1'b0;
      r_if_rdata    <= '0;
      r_dp_rdata    <= '0;
      r_mem_address <= '0;
      r_mem_data_in <= '0;
      r_mem_rd      <= 1'b0;
      r_mem_wr      <= 1'b0;
    end else begin
      r_if_gnt   <= 1'b0;
      r_dp_gnt   <= 1'b0;
      r_if_valid <= 1'b0;
      r_dp_valid <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_mem_wr   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            // Command and grant are set up here so they appear during ISSUE
            r_sel_dp      <= w_pick_dp;
            r_we          <= w_pick_dp & bus.dp_we;
            r_mem_address <= w_pick_dp ? bus.dp_addr : bus.if_addr;
            r_mem_data_in <= w_pick_dp ? bus.dp_wdata : '0;
            r_mem_rd      <= ~(w_pick_dp & bus.dp_we);
            r_mem_wr      <= w_pick_dp & bus.dp_we;
            r_if_gnt      <= ~w_pick_dp;
            r_dp_gnt      <= w_pick_dp;
            r_last_if     <= ~w_pick_dp;
            if (!w_pick_dp) begin
              r_wait_cnt <= '0;
            end else if (bus.if_req && RR_MODE == 0) begin
              r_wait_cnt <= r_wait_cnt + WC_W'(1);
            end
            r_busy  <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_lat_cnt <= '0;
          if (r_we) begin
            // Writes complete with the command; respond right away
            r_dp_valid <= 1'b1;
            r_dp_rdata <= '0;
            r_state    <= S_RESP;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_lat_cnt == LC_W'(RD_LAT - 1)) begin
            if (r_sel_dp) begin
              r_dp_rdata <= bus.mem_data_out;
              r_dp_valid <= 1'b1;
            end else begin
              r_if_rdata <= bus.mem_data_out;
              r_if_valid <= 1'b1;
            end
            r_state <= S_RESP;
          end else begin
            r_lat_cnt <= r_lat_cnt + LC_W'(1);
          end
        end
        S_RESP: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.if_gnt      = r_if_gnt;
  assign bus.if_valid    = r_if_valid;
  assign bus.if_rdata    = r_if_rdata;
  assign bus.dp_gnt      = r_dp_gnt;
  assign bus.dp_valid    = r_dp_valid;
  assign bus.dp_rdata    = r_dp_rdata;
  assign bus.mem_address = r_mem_address;
  assign bus.mem_data_in = r_mem_data_in;
  assign bus.mem_rd      = r_mem_rd;
  assign bus.mem_wr      = r_mem_wr;
  assign busy            = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter across latency/arbitration variants
module tb_mem_arbiter;

  localparam int NI   = 3;
  localparam int MAXW = 3;
  localparam int LATS [NI] = '{1, 3, 1};
  localparam int RRM  [NI] = '{0, 0, 1};

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [NI-1:0] if_req_a, dp_req_a, dp_we_a;
  logic [31:0]   if_addr_a [NI];
  logic [31:0]   dp_addr_a [NI];
  logic [31:0]   dp_wdata_a [NI];
  logic [NI-1:0] if_gnt_a, if_valid_a, dp_gnt_a, dp_valid_a, mem_rd_a, mem_wr_a, busy_a;
  logic [31:0]   if_rdata_a [NI];
  logic [31:0]   dp_rdata_a [NI];
  logic [31:0]   mem_addr_a [NI];
  logic [31:0]   mem_din_a [NI];
  logic [31:0]   pipe [NI][4];

  logic [31:0] mm [int];
  logic [31:0] ref_mem [int];
  int          m_wait [NI];
  bit          m_last_if [NI];
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = (g == 1) ? 3 : 1;
    localparam int R = (g == 2) ? 1 : 0;
    mem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();
    assign bus.if_req       = if_req_a[g];
    assign bus.if_addr      = if_addr_a[g];
    assign bus.dp_req       = dp_req_a[g];
    assign bus.dp_we        = dp_we_a[g];
    assign bus.dp_addr      = dp_addr_a[g];
    assign bus.dp_wdata     = dp_wdata_a[g];
    assign bus.mem_data_out = pipe[g][L-1];
    assign if_gnt_a[g]      = bus.if_gnt;
    assign if_valid_a[g]    = bus.if_valid;
    assign if_rdata_a[g]    = bus.if_rdata;
    assign dp_gnt_a[g]      = bus.dp_gnt;
    assign dp_valid_a[g]    = bus.dp_valid;
    assign dp_rdata_a[g]    = bus.dp_rdata;
    assign mem_addr_a[g]    = bus.mem_address;
    assign mem_din_a[g]     = bus.mem_data_in;
    assign mem_rd_a[g]      = bus.mem_rd;
    assign mem_wr_a[g]      = bus.mem_wr;
    mem_arbiter #(.DATA_W(32), .ADDR_W(32), .RD_LAT(L), .RR_MODE(R), .MAX_WAIT(MAXW)) u_dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy_a[g])
    );
  end

  function automatic logic [31:0] init_word(input int i);
    case (i)
      512:     return 32'hC200_2844;
      513:     return 32'h8280_4002;
      529:     return 32'h0000_0001;
      default: return (32'(i) * 32'h0100_0193) ^ 32'hA5A5_0F0F;
    endcase
  endfunction

  function automatic logic [31:0] mm_rd(input logic [31:0] a);
    int i;
    i = int'(a[11:2]);
    return mm.exists(i) ? mm[i] : init_word(i);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    int i;
    i = int'(a[11:2]);
    return ref_mem.exists(i) ? ref_mem[i] : init_word(i);
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'((600 + $urandom_range(0, 31)) * 4);
  endfunction

  // main_memory model: write on wr, read data RD_LAT cycles after rd is sampled
  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (mem_wr_a[g]) mm[int'(mem_addr_a[g][11:2])] = mem_din_a[g];
      for (int j = 3; j > 0; j--) pipe[g][j] <= pipe[g][j-1];
      if (mem_rd_a[g]) pipe[g][0] <= mm_rd(mem_addr_a[g]);
    end
  end

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_wait[k]    = 0;
      m_last_if[k] = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      n_total++;
      if ({busy_a[k], if_gnt_a[k], dp_gnt_a[k], if_valid_a[k], dp_valid_a[k], mem_rd_a[k], mem_wr_a[k]} !== 7'd0)
        $display("FAIL reset_ctrl inst%0d got %b want 0", k,
                 {busy_a[k], if_gnt_a[k], dp_gnt_a[k], if_valid_a[k], dp_valid_a[k], mem_rd_a[k], mem_wr_a[k]});
      else n_pass++;
      n_total++;
      if (mem_addr_a[k] !== 32'd0) $display("FAIL reset_addr inst%0d got %h want 0", k, mem_addr_a[k]);
      else n_pass++;
      n_total++;
      if (if_rdata_a[k] !== 32'd0) $display("FAIL reset_if_rdata inst%0d got %h want 0", k, if_rdata_a[k]);
      else n_pass++;
      n_total++;
      if ({dp_rdata_a[k], mem_din_a[k]} !== 64'd0) $display("FAIL reset_dp inst%0d got %h want 0", k, {dp_rdata_a[k], mem_din_a[k]});
      else n_pass++;
    end
  endtask

  // One arbitration round: raise the chosen requests together, follow every grant and response
  task automatic run_round(input int k, input bit rq_if, input bit rq_dp, input bit we,
                           input logic [31:0] a_if, input logic [31:0] a_dp, input logic [31:0] wd);
    bit pend_if, pend_dp, fl_if, fl_dp, exp_dp;
    int cyc, t_if, t_dp;
    logic [31:0] e_if, e_dp;
    @(negedge clk);
    if_addr_a[k] = a_if; dp_addr_a[k] = a_dp; dp_we_a[k] = we; dp_wdata_a[k] = wd;
    if_req_a[k] = rq_if; dp_req_a[k] = rq_dp;
    pend_if = rq_if; pend_dp = rq_dp; fl_if = 0; fl_dp = 0;
    cyc = 0; t_if = 0; t_dp = 0; e_if = '0; e_dp = '0;
    while ((pend_if || pend_dp || fl_if || fl_dp) && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (if_gnt_a[k] || dp_gnt_a[k]) begin
        exp_dp = (pend_if && pend_dp) ? (RRM[k] != 0 ? m_last_if[k] : (m_wait[k] < MAXW)) : pend_dp;
        n_total++;
        if (!(pend_if || pend_dp) || {if_gnt_a[k], dp_gnt_a[k]} !== {!exp_dp, exp_dp})
          $display("FAIL grant inst%0d got if/dp=%b%b want %b%b", k, if_gnt_a[k], dp_gnt_a[k], !exp_dp, exp_dp);
        else n_pass++;
        if (exp_dp) begin
          n_total++;
          if ({mem_rd_a[k], mem_wr_a[k], mem_addr_a[k]} !== {!we, we, a_dp})
            $display("FAIL dp_cmd inst%0d got rd=%b wr=%b a=%h want rd=%b wr=%b a=%h", k,
                     mem_rd_a[k], mem_wr_a[k], mem_addr_a[k], !we, we, a_dp);
          else n_pass++;
          if (we) begin
            n_total++;
            if (mem_din_a[k] !== wd) $display("FAIL dp_wdata inst%0d got %h want %h", k, mem_din_a[k], wd);
            else n_pass++;
            ref_mem[int'(a_dp[11:2])] = wd;
            e_dp = '0;
          end else begin
            e_dp = ref_rd(a_dp);
          end
          if (pend_if) m_wait[k]++;
          m_last_if[k] = 1'b0;
          pend_dp = 0; dp_req_a[k] = 1'b0; fl_dp = 1; t_dp = cyc;
        end else begin
          n_total++;
          if ({mem_rd_a[k], mem_wr_a[k], mem_addr_a[k]} !== {1'b1, 1'b0, a_if})
            $display("FAIL if_cmd inst%0d got rd=%b wr=%b a=%h want rd=1 wr=0 a=%h", k,
                     mem_rd_a[k], mem_wr_a[k], mem_addr_a[k], a_if);
          else n_pass++;
          e_if = ref_rd(a_if);
          m_wait[k] = 0;
          m_last_if[k] = 1'b1;
          pend_if = 0; if_req_a[k] = 1'b0; fl_if = 1; t_if = cyc;
        end
      end else if (fl_if || fl_dp) begin
        n_total++;
        if ({mem_rd_a[k], mem_wr_a[k]} !== 2'b00)
          $display("FAIL mem_quiet inst%0d got rd=%b wr=%b want 00", k, mem_rd_a[k], mem_wr_a[k]);
        else n_pass++;
      end
      if (fl_if || fl_dp) begin
        n_total++;
        if (busy_a[k] !== 1'b1) $display("FAIL busy inst%0d got %b want 1", k, busy_a[k]);
        else n_pass++;
      end
      if (if_valid_a[k]) begin
        n_total++;
        if (!fl_if || (cyc - t_if) != LATS[k] + 1)
          $display("FAIL if_latency inst%0d got %0d want %0d", k, cyc - t_if, LATS[k] + 1);
        else n_pass++;
        n_total++;
        if (if_rdata_a[k] !== e_if) $display("FAIL if_rdata inst%0d got %h want %h", k, if_rdata_a[k], e_if);
        else n_pass++;
        fl_if = 0;
      end
      if (dp_valid_a[k]) begin
        n_total++;
        if (!fl_dp || (cyc - t_dp) != (we ? 1 : LATS[k] + 1))
          $display("FAIL dp_latency inst%0d got %0d want %0d", k, cyc - t_dp, we ? 1 : LATS[k] + 1);
        else n_pass++;
        n_total++;
        if (dp_rdata_a[k] !== e_dp) $display("FAIL dp_rdata inst%0d got %h want %h", k, dp_rdata_a[k], e_dp);
        else n_pass++;
        fl_dp = 0;
      end
    end
    if_req_a[k] = 1'b0; dp_req_a[k] = 1'b0;
    n_total++;
    if (cyc >= 100) $display("FAIL round_timeout inst%0d got %0d cycles want <100", k, cyc);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({busy_a[k], if_valid_a[k], dp_valid_a[k]} !== 3'b000)
      $display("FAIL idle_after inst%0d got %b want 000", k, {busy_a[k], if_valid_a[k], dp_valid_a[k]});
    else n_pass++;
  endtask

  task automatic test_single_fetch();
    run_round(0, 1, 0, 0, 32'd2048, 32'd0, 32'd0);
    n_total++;
    if (if_rdata_a[0] !== 32'hC200_2844) $display("FAIL single_fetch got %h want C2002844", if_rdata_a[0]);
    else n_pass++;
  endtask

  task automatic test_write_read();
    run_round(0, 0, 1, 1, 32'd0, 32'd2088, 32'h0000_000D);
    run_round(0, 0, 1, 0, 32'd0, 32'd2088, 32'd0);
    n_total++;
    if (dp_rdata_a[0] !== 32'h0000_000D) $display("FAIL write_read got %h want 0000000D", dp_rdata_a[0]);
    else n_pass++;
    n_total++;
    if (if_rdata_a[0] !== 32'hC200_2844) $display("FAIL if_rdata_hold got %h want C2002844", if_rdata_a[0]);
    else n_pass++;
  endtask

  // Both requests held high; each grant is re-requested until ngr grants have been seen
  task automatic test_hold_both(input int k, input int ngr, input logic [7:0] want_seq);
    bit pend_if, pend_dp, exp_dp;
    int cyc, n, last_t, w;
    logic [7:0] seq;
    @(negedge clk);
    if_addr_a[k] = 32'd2048; dp_addr_a[k] = 32'd2052; dp_we_a[k] = 1'b0; dp_wdata_a[k] = '0;
    if_req_a[k] = 1'b1; dp_req_a[k] = 1'b1;
    pend_if = 1; pend_dp = 1; cyc = 0; n = 0; last_t = -1; seq = '0;
    while ((pend_if || pend_dp) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (if_gnt_a[k] || dp_gnt_a[k]) begin
        exp_dp = (pend_if && pend_dp) ? (RRM[k] != 0 ? m_last_if[k] : (m_wait[k] < MAXW)) : pend_dp;
        n_total++;
        if ({if_gnt_a[k], dp_gnt_a[k]} !== {!exp_dp, exp_dp})
          $display("FAIL hold_grant inst%0d #%0d got if/dp=%b%b want %b%b", k, n, if_gnt_a[k], dp_gnt_a[k], !exp_dp, exp_dp);
        else n_pass++;
        if (last_t >= 0) begin
          n_total++;
          if (cyc - last_t != LATS[k] + 3)
            $display("FAIL hold_spacing inst%0d got %0d want %0d", k, cyc - last_t, LATS[k] + 3);
          else n_pass++;
        end
        if (n < 8) seq[7-n] = dp_gnt_a[k];
        if (exp_dp) begin
          if (pend_if) m_wait[k]++;
          m_last_if[k] = 1'b0;
        end else begin
          m_wait[k] = 0;
          m_last_if[k] = 1'b1;
        end
        n++;
        last_t = cyc;
        if (n >= ngr) begin
          if (exp_dp) begin dp_req_a[k] = 1'b0; pend_dp = 0; end
          else begin if_req_a[k] = 1'b0; pend_if = 0; end
        end
      end
    end
    if_req_a[k] = 1'b0; dp_req_a[k] = 1'b0;
    n_total++;
    if (seq !== want_seq) $display("FAIL hold_order inst%0d got %b want %b (1=dp)", k, seq, want_seq);
    else n_pass++;
    w = 0;
    while (busy_a[k] && w < 20) begin @(negedge clk); w++; end
    n_total++;
    if (cyc >= 200 || w >= 20) $display("FAIL hold_timeout inst%0d got cyc=%0d drain=%0d", k, cyc, w);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [1:0] pat;
    for (int k = 0; k < NI; k++) begin
      for (int r = 0; r < 12; r++) begin
        pat = 2'($urandom_range(1, 3));
        run_round(k, pat[0], pat[1], 1'($urandom_range(0, 1)), rand_addr(), rand_addr(), $urandom);
      end
    end
  endtask

  task automatic test_rdlat3();
    run_round(1, 1, 0, 0, 32'd2116, 32'd0, 32'd0);
    n_total++;
    if (if_rdata_a[1] !== 32'd1) $display("FAIL rdlat3_data got %h want 00000001", if_rdata_a[1]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    int w;
    @(negedge clk);
    if_addr_a[0] = 32'd2048; if_req_a[0] = 1'b1;
    w = 0;
    do begin @(negedge clk); w++; end while (!if_gnt_a[0] && w < 20);
    if_req_a[0] = 1'b0;
    n_total++;
    if (!if_gnt_a[0]) $display("FAIL midrd_gnt got 0 want 1");
    else n_pass++;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_total++;
    if ({busy_a[0], if_gnt_a[0], if_valid_a[0], dp_valid_a[0], mem_rd_a[0], mem_wr_a[0]} !== 6'd0)
      $display("FAIL midrd_async got %b want 0", {busy_a[0], if_gnt_a[0], if_valid_a[0], dp_valid_a[0], mem_rd_a[0], mem_wr_a[0]});
    else n_pass++;
    n_total++;
    if ({mem_addr_a[0], if_rdata_a[0]} !== 64'd0)
      $display("FAIL midrd_regs got addr=%h rdata=%h want 0", mem_addr_a[0], if_rdata_a[0]);
    else n_pass++;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 2) rst = 1'b1;
      n_total++;
      if (if_valid_a[0] !== 1'b0) $display("FAIL midrd_novalid cycle%0d got 1 want 0", c);
      else n_pass++;
    end
    run_round(0, 1, 0, 0, 32'd2052, 32'd0, 32'd0);
    n_total++;
    if (if_rdata_a[0] !== 32'h8280_4002) $display("FAIL midrd_refetch got %h want 82804002", if_rdata_a[0]);
    else n_pass++;
  endtask

  initial begin
    if_req_a = '0; dp_req_a = '0; dp_we_a = '0;
    for (int k = 0; k < NI; k++) begin
      if_addr_a[k] = '0; dp_addr_a[k] = '0; dp_wdata_a[k] = '0;
    end
    model_reset();
    test_reset();
    test_single_fetch();
    test_write_read();
    test_hold_both(0, 8, 8'b1110_1110);
    test_hold_both(2, 8, 8'b0101_0101);
    test_random();
    test_rdlat3();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-ported main_memory.
- Shares main_memory between the instruction-fetch path (read-only) and the datapath load/store path (read/write).
- Issues exactly one memory command at a time and waits the fixed read latency.
- Returns read data / write acknowledge to the granted requester.
- Sits between the ARC control unit and main_memory in the datapath top level.

Parameters:
- DATA_W, 32, data width of all data buses
- ADDR_W, 32, address width of all address buses
- RD_LAT, 1, cycles from mem_rd sampled to mem_data_out valid; 1..4 supported
- RR_MODE, 0, 0 = fixed priority with the datapath winning, 1 = round-robin
- MAX_WAIT, 3, fixed mode only: after this many consecutive lost arbitrations, fetch is forced to win

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  reset; asynchronous, active-low (asserted at 0)
- if_req  in  1  fetch request; held high with if_addr stable until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  one-cycle pulse: fetch command issued
- if_valid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DATA_W  fetched instruction word
- dp_req  in  1  datapath request; held high with dp_we, dp_addr and dp_wdata stable until dp_gnt
- dp_we  in  1  1 = write, 0 = read
- dp_addr  in  ADDR_W  data address
- dp_wdata  in  DATA_W  store data
- dp_gnt  out  1  one-cycle pulse: datapath command issued
- dp_valid  out  1  one-cycle pulse: read data valid or write complete
- dp_rdata  out  DATA_W  load data; 0 after a write
- mem_address  out  ADDR_W  to main_memory address
- mem_data_in  out  DATA_W  to main_memory data_in
- mem_rd  out  1  to main_memory rd
- mem_wr  out  1  to main_memory wr
- mem_data_out  in  DATA_W  from main_memory data_out
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, asynchronous): FSM goes to IDLE.
  - All outputs 0. Latency counter, wait counter and last-grant bit are 0.
  - Any in-flight transaction is dropped with no valid pulse.
  - Operation resumes on the first clk edge after rst returns to 1.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No request pending: stay in IDLE.
  - Any request pending: arbitrate, latch the winner's address, we and wdata, go to ISSUE.
- ISSUE (one cycle, cycle T):
  - Drive mem_rd=~we and mem_wr=we for the winner; datapath only can write, fetch is always a read.
  - Drive mem_address and mem_data_in from the latches.
  - Pulse the winner's gnt.
  - Next state: WAIT if read, RESP if write.
- WAIT:
  - mem_rd and mem_wr are 0.
  - Counter runs RD_LAT cycles, then mem_data_out is captured into the winner's rdata.
  - Next state: RESP.
- RESP (one cycle):
  - Pulse the winner's valid.
  - Next state: IDLE. A new arbitration happens in IDLE the following cycle.
- Latency:
  - Read: valid is high in cycle T+RD_LAT+1.
  - Write: valid is high in cycle T+1.
  - Back-to-back throughput: one read per RD_LAT+3 cycles, one write per 3 cycles.
- rdata holds its value until the next response to the same port.
- Arbitration, fixed mode (RR_MODE=0):
  - dp wins a simultaneous request.
  - wait_cnt increments each time fetch loses, and clears when fetch is granted.
  - When wait_cnt==MAX_WAIT, fetch wins the next conflict.
- Arbitration, round-robin mode (RR_MODE=1):
  - On a conflict, the port not granted last wins.
  - A lone requester always wins.
- A request deasserted before its gnt is a protocol violation; the arbiter only samples requests in IDLE.
- Address is passed through unchanged; no alignment check. Unmapped addresses follow main_memory's default behaviour.
- A request arriving while busy is serviced after RESP in arbitration order; it is never lost.

Test Plan:
- Single fetch: if_req with if_addr=2048, RD_LAT=1 → if_gnt at T, mem_rd=1 and mem_address=2048 at T, if_valid at T+2 with if_rdata=32'hC2002844.
- Data write then read: dp write 32'h0000000D to 2088, then dp read 2088 → write dp_valid at T+1 with mem_wr=1 only at T; read returns 32'h0000000D.
- Conflict, fixed mode with MAX_WAIT=3: dp_req and if_req held high continuously → grant order dp, dp, dp, if, dp, dp, dp, if.
- Conflict, round-robin mode: both requests held high → grants alternate if/dp; never two consecutive grants to the same port while the other requests.
- Reset mid-read: drop rst to 0 during WAIT → all outputs 0 immediately with no clk edge, no valid pulse; after release a fresh fetch of 2052 returns 32'h82804002.
- RD_LAT=3: fetch 2116 → if_valid exactly at T+4 with if_rdata=1; busy high from ISSUE through RESP.
